// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch block.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PC_RD   = 3'd1,
    PC_LAT  = 3'd2,
    MEM     = 3'd3,
    IR_HOLD = 3'd4,
    ERR     = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Memory wait counter: cleared on MEM entry, counts MEM cycles, flags the last allowed cycle.
module fetch_timeout_cnt
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates on the last cycle so a stalled FSM cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: PC read, address latch, memory read with timeout, IR handoff.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              pc_incr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic              pc_en_q, pc_en_d;
  logic              pc_incr_q, pc_incr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_out_q, ir_out_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              tmo_c;

  fetch_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == PC_LAT),
    .en_i  (state_q == MEM),
    .tc_c_o(tmo_c)
  );

  // Outputs are computed for the next state, so every one leaves a flop.
  always_comb begin
    state_d     = state_q;
    pc_en_d     = 1'b0;
    pc_incr_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    ir_out_d    = ir_out_q;
    ir_valid_d  = 1'b0;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = PC_RD;
          pc_en_d = 1'b1;
        end
      end
      PC_RD: begin
        state_d = flush ? IDLE : PC_LAT;
      end
      PC_LAT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d    = MEM;
          mem_addr_d = pc_addr;
          mem_req_d  = 1'b1;
        end
      end
      MEM: begin
        // Flush beats ack; ack beats a coincident timeout.
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          state_d    = IR_HOLD;
          ir_out_d   = mem_rdata;
          ir_valid_d = 1'b1;
          pc_incr_d  = 1'b1;
        end else if (tmo_c) begin
          state_d     = ERR;
          fetch_err_d = 1'b1;
          mem_addr_d  = '0;
          ir_out_d    = '0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      IR_HOLD: begin
        ir_valid_d = 1'b1;
        if (flush) begin
          state_d    = IDLE;
          ir_valid_d = 1'b0;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          if (run) begin
            state_d = PC_RD;
            pc_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_en_q     <= 1'b0;
      pc_incr_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ir_out_q    <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_en_q     <= pc_en_d;
      pc_incr_q   <= pc_incr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_out_q    <= ir_out_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign pc_en     = pc_en_q;
  assign pc_incr   = pc_incr_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir_out    = ir_out_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

endmodule
